// File: rtl/niski_sevseg_ctrl.sv
// Memory-mapped multiplexed seven-segment controller: bus register file, free-running
// digit scan, frame-aligned shadow copy of the display registers, PWM brightness.
module niski_sevseg_ctrl #(
    parameter int DIGITS     = 4,
    parameter int SLOT_BITS  = 16,
    parameter int ACTIVE_LOW = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bus_req,
    input  logic              bus_we,
    input  logic [1:0]        bus_addr,
    input  logic [31:0]       bus_wdata,
    output logic [31:0]       bus_rdata,
    output logic              bus_ack,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] sel
);

    localparam int VW    = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [6:0]        SEG_MASK = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [DIGITS-1:0] SEL_MASK = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : '0;

    logic [VW-1:0]        value_q, value_d, sh_value_q;
    logic [DIGITS-1:0]    en_q, en_d, sh_en_q;
    logic [2:0]           bright_q, bright_d, sh_bright_q;
    logic [SLOT_BITS-1:0] slot_cnt_q;
    logic [IDX_W-1:0]     idx_q;
    logic                 ack_q;
    logic [31:0]          rdata_q, rdata_d;
    logic [6:0]           seg_q, seg_d;
    logic [DIGITS-1:0]    sel_q, sel_d;

    logic                 accept;
    logic                 slot_wrap;
    logic                 frame_wrap;
    logic                 lit;
    logic [3:0]           nib [DIGITS];
    logic                 unused_wdata;

    assign unused_wdata = ^bus_wdata;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
        assign nib[gi] = sh_value_q[gi*4 +: 4];
    end

    always_comb begin
        accept   = bus_req && !ack_q;
        value_d  = value_q;
        en_d     = en_q;
        bright_d = bright_q;
        rdata_d  = '0;
        if (accept && bus_we) begin
            case (bus_addr)
                2'd0:    value_d  = bus_wdata[VW-1:0];
                2'd1:    en_d     = bus_wdata[DIGITS-1:0];
                2'd2:    bright_d = bus_wdata[2:0];
                default: ;
            endcase
        end
        if (accept && !bus_we) begin
            case (bus_addr)
                2'd0:    rdata_d[VW-1:0]     = value_q;
                2'd1:    rdata_d[DIGITS-1:0] = en_q;
                2'd2:    rdata_d[2:0]        = bright_q;
                default: ;
            endcase
        end

        slot_wrap  = (slot_cnt_q == '1);
        frame_wrap = slot_wrap && (idx_q == IDX_LAST);

        // Dimming gates the top three slot-counter bits against the shadow brightness.
        lit   = sh_en_q[idx_q] && (slot_cnt_q[SLOT_BITS-1 -: 3] <= sh_bright_q);
        seg_d = lit ? hex7(nib[idx_q]) : 7'h00;
        sel_d = lit ? (DIGITS'(1) << idx_q) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q     <= '0;
            en_q        <= '1;
            bright_q    <= 3'd7;
            sh_value_q  <= '0;
            sh_en_q     <= '1;
            sh_bright_q <= 3'd7;
            slot_cnt_q  <= '0;
            idx_q       <= '0;
            ack_q       <= 1'b0;
            rdata_q     <= '0;
            seg_q       <= SEG_MASK;
            sel_q       <= SEL_MASK;
        end else begin
            value_q    <= value_d;
            en_q       <= en_d;
            bright_q   <= bright_d;
            ack_q      <= accept;
            rdata_q    <= rdata_d;
            slot_cnt_q <= slot_cnt_q + SLOT_BITS'(1);
            if (slot_wrap) begin
                idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            end
            // Shadows take the post-write register values so a write on the wrap edge lands.
            if (frame_wrap) begin
                sh_value_q  <= value_d;
                sh_en_q     <= en_d;
                sh_bright_q <= bright_d;
            end
            seg_q <= seg_d ^ SEG_MASK;
            sel_q <= sel_d ^ SEL_MASK;
        end
    end

    assign bus_ack   = ack_q;
    assign bus_rdata = rdata_q;
    assign seg       = seg_q;
    assign sel       = sel_q;

endmodule

// File: tb/tb_niski_sevseg_ctrl.sv
// Directed bench for niski_sevseg_ctrl with 16-cycle slots and active-low pins.
module tb_niski_sevseg_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        bus_req;
    logic        bus_we;
    logic [1:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic [6:0]  seg;
    logic [3:0]  sel;

    int checks = 0;
    int errors = 0;
    int k = 0;
    logic [31:0] rd;

    niski_sevseg_ctrl #(
        .DIGITS(4),
        .SLOT_BITS(4),
        .ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus_req(bus_req),
        .bus_we(bus_we),
        .bus_addr(bus_addr),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .bus_ack(bus_ack),
        .seg(seg),
        .sel(sel)
    );

    always #5 clk = ~clk;

    // Edges since reset release; after edge k the pins show slot position k-1.
    always @(posedge clk) begin
        if (rst) k <= 0;
        else     k <= k + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s k=%0d got=%h exp=%h", tag, k, got, exp);
        end else begin
            $display("ok   %s k=%0d val=%h", tag, k, got);
        end
    endtask

    task automatic wait_k(input int t);
        while (k < t) @(negedge clk);
        check_eq("timeline", k, t);
    endtask

    task automatic pins(input string tag, input logic [3:0] exp_sel, input logic [6:0] exp_seg);
        check_eq({tag, ".sel"}, {28'd0, sel}, {28'd0, exp_sel});
        check_eq({tag, ".seg"}, {25'd0, seg}, {25'd0, exp_seg});
    endtask

    task automatic bus_xfer(input logic we, input logic [1:0] addr, input logic [31:0] wd,
                            output logic [31:0] rdo);
        logic got;
        got       = 1'b0;
        bus_req   = 1'b1;
        bus_we    = we;
        bus_addr  = addr;
        bus_wdata = wd;
        rdo       = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus_ack) begin
                got = 1'b1;
                rdo = bus_rdata;
                break;
            end
        end
        bus_req = 1'b0;
        bus_we  = 1'b0;
        check_eq("bus_ack", {31'd0, got}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; bus_req = 1'b0; bus_we = 1'b0; bus_addr = 2'd0; bus_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        pins("reset", 4'hF, 7'h7F);
        check_eq("reset.ack", {31'd0, bus_ack}, 32'd0);
        check_eq("reset.rdata", bus_rdata, 32'd0);
        rst = 1'b0;

        // Scan of reset value 0 on all digits
        wait_k(1);  pins("scan.d0", 4'hE, 7'h40);
        wait_k(16); pins("scan.d0end", 4'hE, 7'h40);
        wait_k(17); pins("scan.d1", 4'hD, 7'h40);
        wait_k(33); pins("scan.d2", 4'hB, 7'h40);
        wait_k(49); pins("scan.d3", 4'h7, 7'h40);

        bus_xfer(1'b1, 2'd0, 32'h0000_12AF, rd);
        check_eq("wr.rdata", rd, 32'd0);
        @(negedge clk);
        check_eq("ack.pulse", {31'd0, bus_ack}, 32'd0);
        bus_xfer(1'b0, 2'd0, 32'd0, rd);
        check_eq("rd.value", rd, 32'h0000_12AF);

        wait_k(64); pins("old.d3", 4'h7, 7'h40);
        wait_k(65); pins("12AF.d0", 4'hE, 7'h0E);
        wait_k(81); pins("12AF.d1", 4'hD, 7'h08);
        wait_k(97); pins("12AF.d2", 4'hB, 7'h24);
        bus_xfer(1'b1, 2'd0, 32'h0000_0000, rd);
        wait_k(113); pins("torn.d3", 4'h7, 7'h79);
        wait_k(129); pins("zero.d0", 4'hE, 7'h40);
        wait_k(145); pins("zero.d1", 4'hD, 7'h40);

        bus_xfer(1'b1, 2'd1, 32'h0000_0005, rd);
        bus_xfer(1'b0, 2'd1, 32'd0, rd);
        check_eq("rd.en", rd, 32'h5);
        wait_k(193); pins("en.d0", 4'hE, 7'h40);
        wait_k(209); pins("en.d1off", 4'hF, 7'h7F);
        wait_k(224); pins("en.d1end", 4'hF, 7'h7F);
        wait_k(225); pins("en.d2", 4'hB, 7'h40);
        wait_k(241); pins("en.d3off", 4'hF, 7'h7F);

        bus_xfer(1'b1, 2'd2, 32'h0000_0001, rd);
        wait_k(256); pins("en.d3end", 4'hF, 7'h7F);
        wait_k(257); pins("b1.c0", 4'hE, 7'h40);
        wait_k(260); pins("b1.c3", 4'hE, 7'h40);
        wait_k(261); pins("b1.c4", 4'hF, 7'h7F);
        wait_k(272); pins("b1.c15", 4'hF, 7'h7F);
        wait_k(289); pins("b1.d2c0", 4'hB, 7'h40);
        wait_k(292); pins("b1.d2c3", 4'hB, 7'h40);
        wait_k(293); pins("b1.d2c4", 4'hF, 7'h7F);

        bus_xfer(1'b1, 2'd2, 32'h0000_0000, rd);
        wait_k(321); pins("b0.c0", 4'hE, 7'h40);
        wait_k(322); pins("b0.c1", 4'hE, 7'h40);
        wait_k(323); pins("b0.c2", 4'hF, 7'h7F);

        bus_xfer(1'b1, 2'd2, 32'h0000_0007, rd);
        bus_xfer(1'b0, 2'd2, 32'd0, rd);
        check_eq("rd.bright", rd, 32'h7);

        // Request held through the ack cycle must not start a second access
        @(negedge clk);
        check_eq("idle.ack", {31'd0, bus_ack}, 32'd0);
        bus_req = 1'b1; bus_we = 1'b0; bus_addr = 2'd2;
        @(negedge clk);
        check_eq("hold.ack1", {31'd0, bus_ack}, 32'd1);
        check_eq("hold.rdata", bus_rdata, 32'h7);
        @(negedge clk);
        check_eq("hold.ack2", {31'd0, bus_ack}, 32'd0);
        check_eq("hold.rdata0", bus_rdata, 32'd0);
        bus_req = 1'b0;

        // Reset in the middle of a lit slot and with an ack pending
        wait_k(390); pins("b7.d0", 4'hE, 7'h40);
        bus_req = 1'b1; bus_we = 1'b0; bus_addr = 2'd1;
        @(negedge clk);
        check_eq("pre.ack", {31'd0, bus_ack}, 32'd1);
        check_eq("pre.rdata", bus_rdata, 32'h5);
        pins("pre.rst", 4'hE, 7'h40);
        rst = 1'b1; bus_req = 1'b0;
        @(negedge clk);
        pins("midrst", 4'hF, 7'h7F);
        check_eq("midrst.ack", {31'd0, bus_ack}, 32'd0);
        check_eq("midrst.rdata", bus_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        bus_xfer(1'b0, 2'd1, 32'd0, rd);
        check_eq("rst.en", rd, 32'hF);
        pins("rst.scan", 4'hE, 7'h40);
        bus_xfer(1'b0, 2'd2, 32'd0, rd);
        check_eq("rst.bright", rd, 32'h7);
        bus_xfer(1'b0, 2'd0, 32'd0, rd);
        check_eq("rst.value", rd, 32'h0);
        bus_xfer(1'b1, 2'd3, 32'hFFFF_FFFF, rd);
        bus_xfer(1'b0, 2'd3, 32'd0, rd);
        check_eq("rd.addr3", rd, 32'h0);
        bus_xfer(1'b0, 2'd1, 32'd0, rd);
        check_eq("addr3.noeffect", rd, 32'hF);
        bus_xfer(1'b1, 2'd1, 32'hFFFF_FFF3, rd);
        bus_xfer(1'b0, 2'd1, 32'd0, rd);
        check_eq("rd.en.mask", rd, 32'h3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog k=%0d", k);
        $fatal(1, "timeout");
    end

endmodule
